ed_distance_engine: RTL and testbench

- Multi-cycle, handshaked Euclidean-distance engine for the GAM node-matching path.
- Accepts one input vector `x` and one weight vector `w`, each `VECTOR_LEN` elements of `ELEM_W` bits.
- Per cycle, accumulates squared element differences for `LANES` elements at a time.
- Then takes an iterative integer square root.
- Sits between the node-vector source and the winner-search logic; replaces the single-shot combinational distance path.

---
 rtl/ed_distance_engine_pkg.sv | 17 +
 rtl/ed_distance_engine_isqrt_iter.sv | 77 +++++++
 rtl/ed_distance_engine.sv | 146 ++++++++++++++
 tb/tb_ed_distance_engine.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ed_distance_engine_pkg.sv
// Shared GAM definitions: vector geometry defaults, node vector type,
// distance-engine FSM states and the accumulator width helper.
package GAM_package;

  localparam int VECTOR_LEN = 16;
  localparam int ELEM_W     = 8;

  typedef logic [VECTOR_LEN*ELEM_W-1:0] node_vector_T;

  typedef enum logic [1:0] {IDLE, ACCUM, SQRT, DONE} ed_state_T;

  // Wide enough for VECTOR_LEN full-scale squares without overflow.
  function automatic int acc_width(input int elem_w, input int vlen);
    return 2*elem_w + $clog2(vlen);
  endfunction

endpackage

// File: rtl/ed_distance_engine_isqrt_iter.sv
// Sequential restoring integer square root, one root bit per cycle, MSB first.
// The first bit is resolved on the start edge; done pulses once after the last bit.
module ed_isqrt_iter #(
  parameter  int W  = 20,
  localparam int NS = (W + 1) / 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  operand,
  output logic          busy,
  output logic          done,
  output logic [NS-1:0] root
);

  localparam int CW = $clog2(NS + 1);

  logic [2*NS-1:0] op_reg;
  logic [2*NS-1:0] op_pad;
  logic [NS:0]     rem_reg;
  logic [NS-1:0]   root_reg;
  logic [CW-1:0]   cnt;

  logic [NS:0]     rem_in;
  logic [NS-1:0]   root_in;
  logic [1:0]      bits;
  logic [NS+2:0]   shifted;
  logic [NS+2:0]   trial;
  logic            ge;
  logic [NS:0]     rem_nx;
  logic [NS-1:0]   root_nx;

  assign op_pad = (2*NS)'(operand);
  assign root   = root_reg;

  // Remainder never exceeds 2*root, so NS+1 bits hold it between steps.
  always_comb begin
    rem_in  = start ? '0 : rem_reg;
    root_in = start ? '0 : root_reg;
    bits    = start ? op_pad[2*NS-1 -: 2] : op_reg[2*NS-1 -: 2];
    shifted = {rem_in, bits};
    trial   = {1'b0, root_in, 2'b01};
    ge      = (shifted >= trial);
    rem_nx  = ge ? (NS+1)'(shifted - trial) : (NS+1)'(shifted);
    root_nx = {root_in[NS-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg   <= '0;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      rem_reg  <= rem_nx;
      root_reg <= root_nx;
      op_reg   <= op_pad << 2;
      cnt      <= CW'(NS - 1);
      busy     <= 1'b1;
      done     <= 1'b0;
    end else if (busy) begin
      rem_reg  <= rem_nx;
      root_reg <= root_nx;
      op_reg   <= op_reg << 2;
      cnt      <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/ed_distance_engine.sv
// Handshaked Euclidean-distance engine: LANES squared differences per cycle, then
// an optional iterative root when ED_SQRT_EN is defined (else ed = sq_sum).
module ed_distance_engine
  import GAM_package::*;
#(
  parameter  int ELEM_W = GAM_package::ELEM_W,
  parameter  int LANES  = 4,
  localparam int ACC_W  = acc_width(ELEM_W, VECTOR_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [VECTOR_LEN*ELEM_W-1:0] x,
  input  logic [VECTOR_LEN*ELEM_W-1:0] w,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             sq_sum,
  output logic [31:0]                  ed
);

  localparam int NC   = VECTOR_LEN / LANES;
  localparam int KW   = (NC > 1) ? $clog2(NC) : 1;
  localparam int SQ_W = 2 * ELEM_W;

  generate
    if (VECTOR_LEN % LANES != 0) begin : g_lanes_check
      $error("ed_distance_engine: LANES must divide VECTOR_LEN");
    end
  endgenerate

  ed_state_T                   state;
  logic [VECTOR_LEN*ELEM_W-1:0] x_reg;
  logic [VECTOR_LEN*ELEM_W-1:0] w_reg;
  logic [KW-1:0]               k;
  logic [ACC_W-1:0]            acc;
  logic [ACC_W-1:0]            chunk_sum;
  logic [ACC_W-1:0]            acc_next;
  logic                        last_chunk;
  logic [SQ_W-1:0]             sq [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ELEM_W-1:0] xe;
      logic [ELEM_W-1:0] we;
      logic [ELEM_W-1:0] d;
      assign xe     = x_reg[(int'(k)*LANES + gi)*ELEM_W +: ELEM_W];
      assign we     = w_reg[(int'(k)*LANES + gi)*ELEM_W +: ELEM_W];
      assign d      = (xe >= we) ? (xe - we) : (we - xe);
      assign sq[gi] = SQ_W'(d) * SQ_W'(d);
    end
  endgenerate

  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      chunk_sum = chunk_sum + ACC_W'(sq[i]);
    end
  end

  assign acc_next   = acc + chunk_sum;
  assign last_chunk = (k == KW'(NC - 1));

`ifdef ED_SQRT_EN
  localparam int NS = (ACC_W + 1) / 2;
  logic          sq_start;
  logic          sq_busy;
  logic          sq_done;
  logic [NS-1:0] sq_root;

  // Root starts on the final accumulate edge so its first bit overlaps that cycle.
  assign sq_start = (state == ACCUM) && last_chunk;

  ed_isqrt_iter #(.W(ACC_W)) u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start   (sq_start),
    .operand (acc_next),
    .busy    (sq_busy),
    .done    (sq_done),
    .root    (sq_root)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_reg     <= '0;
      w_reg     <= '0;
      k         <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sq_sum    <= '0;
      ed        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            x_reg    <= x;
            w_reg    <= w;
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          k   <= k + 1'b1;
          if (last_chunk) begin
            sq_sum <= acc_next;
`ifdef ED_SQRT_EN
            state  <= SQRT;
`else
            ed        <= 32'(acc_next);
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end
        end
`ifdef ED_SQRT_EN
        SQRT: begin
          if (sq_done && !sq_busy) begin
            ed        <= 32'(sq_root);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ed_distance_engine.sv
// Self-checking bench for ed_distance_engine: directed table, handshake/reset
// sequences and random vectors against a plain-arithmetic distance model.
module tb_ed_distance_engine;

  localparam int VL    = 16;
  localparam int EW    = 8;
  localparam int VW    = VL * EW;
  localparam int ACC_W = 20;
`ifdef ED_SQRT_EN
  localparam int LAT = 14;
`else
  localparam int LAT = 4;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [VW-1:0]    x = '0;
  logic [VW-1:0]    w = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] sq_sum;
  logic [31:0]      ed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ed_distance_engine dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sq_sum    (sq_sum),
    .ed        (ed)
  );

  typedef struct {
    string         name;
    logic [VW-1:0] vx;
    logic [VW-1:0] vw;
    int            exp_sq;
    int            exp_root;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int model_sq(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int s = 0;
    for (int i = 0; i < VL; i++) begin
      int d = int'(a[i*EW +: EW]) - int'(b[i*EW +: EW]);
      s += d * d;
    end
    return s;
  endfunction

  function automatic int model_isqrt(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic int model_ed(input int s, input int root);
`ifdef ED_SQRT_EN
    return root;
`else
    return s;
`endif
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_vector(input string name, input logic [VW-1:0] vx, input logic [VW-1:0] vw,
                           input int exp_sq, input int exp_ed, input int hold, input bit no_wait);
    int waitc = 0;
    int lat   = 0;
    bit seen  = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (no_wait) check({name, " ready_wait"}, 64'(waitc), 64'd0);
    if (!in_ready) begin
      check({name, " in_ready_timeout"}, 64'(in_ready), 64'd1);
      return;
    end
    in_valid = 1'b1;
    x = vx;
    w = vw;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = rand_vec();
    w = rand_vec();
    while (!seen && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) seen = 1;
      else out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(LAT));
    check({name, " sq_sum"}, 64'(sq_sum), 64'(exp_sq));
    check({name, " ed"}, 64'(ed), 64'(exp_ed));
    check({name, " in_ready_busy"}, 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, " hold"}, {10'd0, out_valid, in_ready, ed, sq_sum},
            {10'd0, 1'b1, 1'b0, 32'(exp_ed), 20'(exp_sq)});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, " release"}, {62'd0, out_valid, in_ready}, 64'd1);
    $display("vec %-12s lat=%0d sq_sum=%0d ed=%0d hold=%0d (exp sq=%0d ed=%0d)",
             name, lat, exp_sq, exp_ed, hold, exp_sq, exp_ed);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t          tbl[5];
    logic [VW-1:0] base;
    logic [VW-1:0] ones;
    int            s;
    int            ov_seen;

    base = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
            8'h0F, 8'hED, 8'hCB, 8'hA9, 8'h87, 8'h65, 8'h43, 8'h21};
    tbl[0] = '{"equal", base, base, 0, 0};
    tbl[1].name = "diff10_7"; tbl[1].vx = {16{8'h55}}; tbl[1].vw = {16{8'h55}};
    tbl[1].vx[7:0] = 8'd10; tbl[1].vw[7:0] = 8'd7; tbl[1].exp_sq = 9; tbl[1].exp_root = 3;
    tbl[2].name = "diff7_10"; tbl[2].vx = tbl[1].vw; tbl[2].vw = tbl[1].vx;
    tbl[2].exp_sq = 9; tbl[2].exp_root = 3;
    ones = '1;
    tbl[3] = '{"full_scale", ones, '0, 1040400, 1020};
    tbl[4].name = "floor_2"; tbl[4].vx = {16{8'h40}}; tbl[4].vw = {16{8'h40}};
    tbl[4].vw[7:0] = 8'h41; tbl[4].vw[127:120] = 8'h3F; tbl[4].exp_sq = 2; tbl[4].exp_root = 1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {in_ready, out_valid, 10'd0, ed, sq_sum}, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'(in_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      do_vector(tbl[i].name, tbl[i].vx, tbl[i].vw, tbl[i].exp_sq,
                model_ed(tbl[i].exp_sq, tbl[i].exp_root), 0, 0);
    end

    // Back-pressure then immediate next acceptance
    do_vector("hold5", tbl[3].vx, tbl[3].vw, 1040400, model_ed(1040400, 1020), 5, 0);
    do_vector("after_hold", tbl[1].vx, tbl[1].vw, 9, model_ed(9, 3), 0, 1);

    // Reset in the second ACCUM cycle while sq_sum still holds a nonzero result
    do_vector("pre_reset", tbl[3].vx, tbl[3].vw, 1040400, model_ed(1040400, 1020), 0, 0);
    in_valid = 1'b1;
    x = tbl[4].vx;
    w = tbl[4].vw;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midop_reset_outputs", {in_ready, out_valid, 10'd0, ed, sq_sum}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midop_ready_after_release", 64'(in_ready), 64'd1);
    ov_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("no_stale_out_valid", 64'(ov_seen), 64'd0);
    do_vector("post_reset", tbl[1].vx, tbl[1].vw, 9, model_ed(9, 3), 0, 0);

    // Random vectors against the model
    for (int i = 0; i < 20; i++) begin
      logic [VW-1:0] rx;
      logic [VW-1:0] rw;
      rx = rand_vec();
      rw = rand_vec();
      if (i % 3 == 1) rw = rx ^ (rand_vec() & {16{8'h07}});
      if (i % 3 == 2) begin
        rw = rx;
        rw[$urandom_range(0, VL-1)*EW +: EW] = 8'($urandom);
      end
      s = model_sq(rx, rw);
      do_vector($sformatf("rand%0d", i), rx, rw, s, model_ed(s, model_isqrt(s)),
                int'($urandom_range(0, 3)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
